h80bus_mem: RTL

Parametrised byte-lane memory slave for the h80 bus, replacing the fixed 64 KiB single-cycle CPU memory. It decodes a configurable address window and supports 32/16/8-bit accesses on correct byte lanes. A programmable number of wait states is inserted through `wait_n`, and it reports alignment faults. It sits on the shared h80bus alongside the CPU and peripheral slaves.

---
 rtl/h80bus_mem.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/h80bus_mem.sv
// rtl/h80bus_mem.sv - byte-lane h80 bus memory slave with address window and programmable wait states
// Define H80MEM_ALIGN_CHECK_EN to fault misaligned word/halfword accesses instead of forcing alignment.
`ifndef SIM_DISPLAY
`define SIM_DISPLAY(msg)
`endif

module h80bus_mem #(
  parameter int unsigned BUS_ADDR_WIDTH = 16,
  parameter int unsigned BUS_CMD_WIDTH  = 3,
  parameter int unsigned BUS_DATA_WIDTH = 32,
  parameter int unsigned MEM_SIZE       = 65536,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned LATENCY        = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce_n,
  input  logic [BUS_ADDR_WIDTH-1:0] addr,
  input  logic [BUS_CMD_WIDTH-1:0]  cmd,
  inout  wire  [BUS_DATA_WIDTH-1:0] data_,
  output logic                      wait_n,
  output logic                      err
);
  localparam logic [BUS_CMD_WIDTH-1:0] bus_cmd_read    = BUS_CMD_WIDTH'(1);
  localparam logic [BUS_CMD_WIDTH-1:0] bus_cmd_write   = BUS_CMD_WIDTH'(2);
  localparam logic [BUS_CMD_WIDTH-1:0] bus_cmd_read_w  = BUS_CMD_WIDTH'(3);
  localparam logic [BUS_CMD_WIDTH-1:0] bus_cmd_write_w = BUS_CMD_WIDTH'(4);
  localparam logic [BUS_CMD_WIDTH-1:0] bus_cmd_read_b  = BUS_CMD_WIDTH'(5);
  localparam logic [BUS_CMD_WIDTH-1:0] bus_cmd_write_b = BUS_CMD_WIDTH'(6);

  localparam int NUM_LANES = BUS_DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NUM_LANES);
  localparam int WORDS     = MEM_SIZE / NUM_LANES;
  localparam int WIDX_BITS = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_BITS  = $clog2(LATENCY + 1);
  localparam logic [BUS_ADDR_WIDTH:0] lo_addr = (BUS_ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [BUS_ADDR_WIDTH:0] win_len = (BUS_ADDR_WIDTH+1)'(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                     state;
  logic [CNT_BITS-1:0]        cnt;
  logic [BUS_DATA_WIDTH-1:0]  rd_data;
  logic [BUS_ADDR_WIDTH-1:0]  l_off;
  logic [BUS_CMD_WIDTH-1:0]   l_cmd;
  logic [BUS_DATA_WIDTH-1:0]  l_data;
  logic [7:0]                 mem [NUM_LANES][WORDS];

  logic [BUS_ADDR_WIDTH:0]    rel;
  logic                       sel;
  logic [BUS_ADDR_WIDTH-1:0]  ex_off;
  logic [BUS_CMD_WIDTH-1:0]   ex_cmd;
  logic [BUS_DATA_WIDTH-1:0]  ex_data;
  logic                       ex_go;
  logic [WIDX_BITS-1:0]       widx;
  int                         lane;
  int                         lane_base;
  int                         acc_size;
  logic                       is_wr;
  logic                       upd_rd;
  logic                       fault;
  logic [NUM_LANES-1:0]       wen;
  logic [7:0]                 wbyte [NUM_LANES];
  logic [BUS_DATA_WIDTH-1:0]  rd_val;

  // Addresses below the window wrap to a large offset, so one compare decodes both bounds.
  assign rel = {1'b0, addr} - lo_addr;
  assign sel = !ce_n && (rel < win_len);

  // With LATENCY==1 the access executes on the accept edge, so live inputs stand in for the latches.
  always_comb begin
    ex_off  = (state == IDLE) ? rel[BUS_ADDR_WIDTH-1:0] : l_off;
    ex_cmd  = (state == IDLE) ? cmd : l_cmd;
    ex_data = (state == IDLE) ? data_ : l_data;
    ex_go   = (state == IDLE) ? (sel && LATENCY == 1) : (state == WAIT && cnt == CNT_BITS'(1));
    widx    = WIDX_BITS'(ex_off >> LANE_BITS);
    lane    = int'(ex_off[LANE_BITS-1:0]);
    acc_size = 0;
    is_wr    = 1'b0;
    upd_rd   = 1'b1;
    case (ex_cmd)
      bus_cmd_read:    acc_size = NUM_LANES;
      bus_cmd_write:   begin acc_size = NUM_LANES; is_wr = 1'b1; upd_rd = 1'b0; end
      bus_cmd_read_w:  acc_size = 2;
      bus_cmd_write_w: begin acc_size = 2; is_wr = 1'b1; upd_rd = 1'b0; end
      bus_cmd_read_b:  acc_size = 1;
      bus_cmd_write_b: begin acc_size = 1; is_wr = 1'b1; upd_rd = 1'b0; end
      default:         acc_size = 0;
    endcase
    lane_base = lane & ~(acc_size - 1);
`ifdef H80MEM_ALIGN_CHECK_EN
    fault = (acc_size > 1) && (lane != lane_base);
`else
    fault = 1'b0;
`endif
    wen    = '0;
    rd_val = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      wbyte[k] = 8'h00;
      if (k >= lane_base && k < lane_base + acc_size) begin
        wen[k]   = is_wr && !fault;
        wbyte[k] = ex_data[8*(k-lane_base) +: 8];
        rd_val[8*(k-lane_base) +: 8] = mem[k][widx];
      end
    end
    if (fault) rd_val = '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_data <= '0;
      l_off   <= '0;
      l_cmd   <= '0;
      l_data  <= '0;
    end else begin
      if (ex_go && upd_rd) rd_data <= rd_val;
      case (state)
        IDLE: if (sel) begin
          l_off  <= rel[BUS_ADDR_WIDTH-1:0];
          l_cmd  <= cmd;
          l_data <= data_;
          if (LATENCY == 1) state <= DONE;
          else begin
            state <= WAIT;
            cnt   <= CNT_BITS'(LATENCY - 1);
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_BITS'(1);
          if (cnt == CNT_BITS'(1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && ex_go)
      for (int k = 0; k < NUM_LANES; k++)
        if (wen[k]) mem[k][widx] <= wbyte[k];
  end

`ifdef H80MEM_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else begin
      err_q <= ex_go && fault;
      if (ex_go && fault) begin
        `SIM_DISPLAY(("h80bus_mem: misaligned cmd %0d at addr 0x%0h", ex_cmd, ex_off + BUS_ADDR_WIDTH'(BASE_ADDR)))
      end
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign wait_n = !(sel && state != DONE);
  assign data_  = (sel && cmd[0]) ? rd_data : 'z;
endmodule
